// File: rtl/axi4_default_slave_if.sv
// AXI4 bus bundle for the default (error-terminating) slave.
// Slave modport faces the interconnect; master modport is the requesting side.
interface axi4_default_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid,  output wready,
    output bid, bresp, bvalid,           input  bready,
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid, input  awready,
    output wdata, wstrb, wlast, wvalid,  input  wready,
    input  bid, bresp, bvalid,           output bready,
    output arid, araddr, arlen, arvalid, input  arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi4_default_slave.sv
// AXI4 default slave: accepts every transaction and answers DECERR.
// Optional error logging (err_addr/err_is_write/err_count) under AXI4_DEFSLV_ERRLOG_EN.
module axi4_default_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi4_default_slave_if.slave   axi
`ifdef AXI4_DEFSLV_ERRLOG_EN
  ,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_write,
  output logic [15:0]           err_count
`endif
);

  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t            w_state, w_state_nxt;
  r_state_t            r_state, r_state_nxt;
  logic [ID_WIDTH-1:0] bid_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [7:0]          beat_cnt;

  logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs;

  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_last_hs = axi.wvalid && axi.wready && axi.wlast;
  assign b_hs      = axi.bvalid && axi.bready;
  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_hs      = axi.rvalid && axi.rready;

  // Payload fields are discarded; fold them into a sink so they are not flagged as dangling.
  logic unused_payload;
  assign unused_payload = ^{axi.awaddr, axi.awlen, axi.wdata, axi.wstrb, axi.araddr};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        axi.awready = 1'b1;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi.wready = 1'b1;
        if (w_last_hs) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        axi.bresp  = DECERR;
        if (b_hs) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        axi.arready = 1'b1;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        axi.rvalid = 1'b1;
        axi.rresp  = DECERR;
        axi.rlast  = (beat_cnt == 8'd0);
        if (r_hs && beat_cnt == 8'd0) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Captured IDs and the remaining-beat counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bid_q    <= '0;
      rid_q    <= '0;
      beat_cnt <= 8'd0;
    end else begin
      if (aw_hs) bid_q <= axi.awid;
      if (ar_hs) begin
        rid_q    <= axi.arid;
        beat_cnt <= axi.arlen;
      end else if (r_hs && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

  assign axi.bid   = bid_q;
  assign axi.rid   = rid_q;
  assign axi.rdata = '0;

`ifdef AXI4_DEFSLV_ERRLOG_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A simultaneous AW/AR pair logs the write address but counts both.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_addr     <= '0;
      err_is_write <= 1'b0;
      err_count    <= 16'd0;
    end else if (aw_hs || ar_hs) begin
      err_count    <= sat_add16(err_count, {1'b0, aw_hs} + {1'b0, ar_hs});
      err_is_write <= aw_hs;
      err_addr     <= aw_hs ? ADDR_WIDTH'(axi.awaddr) : ADDR_WIDTH'(axi.araddr);
    end
  end
`endif

endmodule
